// File: rtl/digital_tube_ctrl.sv
// rtl/digital_tube_ctrl.sv - bus-mapped scan controller for three 7-segment tube groups
module digital_tube_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2
);

    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

    logic [31:0] data;
    logic [8:0]  ctrl;
    logic [15:0] cnt;
    logic [1:0]  idx;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        rdata = 32'h0;
        case (addr)
            2'd0:    rdata = data;
            2'd1:    rdata = {23'h0, ctrl};
            2'd2:    rdata = {30'h0, idx};
            default: rdata = 32'h0;
        endcase
    end

    // Nibbles at and above idx; all-zero means the current digit is a leading zero.
    logic [15:0] hi0, hi1;
    logic        blank0, blank1;
    logic [3:0]  sel_nxt;

    always_comb begin
        hi0     = data[15:0] >> {idx, 2'b00};
        hi1     = data[31:16] >> {idx, 2'b00};
        blank0  = ctrl[1] && (idx != 2'd0) && (hi0 == 16'h0);
        blank1  = ctrl[1] && (idx != 2'd0) && (hi1 == 16'h0);
        sel_nxt = 4'b0001 << idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data              <= 32'h0;
            ctrl              <= 9'h0;
            cnt               <= 16'h0;
            idx               <= 2'd0;
            digital_tube0     <= 8'hFF;
            digital_tube1     <= 8'hFF;
            digital_tube2     <= 8'hFF;
            digital_tube_sel0 <= 4'b0000;
            digital_tube_sel1 <= 4'b0000;
            digital_tube_sel2 <= 1'b0;
        end else begin
            if (we && addr == 2'd0)
                data <= wdata;
            if (we && addr == 2'd1)
                ctrl <= {wdata[8:4], 2'b00, wdata[1:0]};

            if (cnt == CNT_LAST) begin
                cnt <= 16'h0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 16'h1;
            end

            if (ctrl[0]) begin
                digital_tube_sel0 <= sel_nxt;
                digital_tube_sel1 <= sel_nxt;
                digital_tube_sel2 <= 1'b1;
                digital_tube0     <= blank0 ? 8'hFF : {1'b1, seg7(hi0[3:0])};
                digital_tube1     <= blank1 ? 8'hFF : {1'b1, seg7(hi1[3:0])};
                digital_tube2     <= {~ctrl[8], seg7(ctrl[7:4])};
            end else begin
                digital_tube_sel0 <= 4'b0000;
                digital_tube_sel1 <= 4'b0000;
                digital_tube_sel2 <= 1'b0;
                digital_tube0     <= 8'hFF;
                digital_tube1     <= 8'hFF;
                digital_tube2     <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_digital_tube_ctrl.sv
// tb/tb_digital_tube_ctrl.sv - randomized check of digital_tube_ctrl against a reference model
module tb_digital_tube_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset, we;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
    logic [3:0]  digital_tube_sel0, digital_tube_sel1;
    logic        digital_tube_sel2;

    digital_tube_ctrl #(.SCAN_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .digital_tube0(digital_tube0), .digital_tube_sel0(digital_tube_sel0),
        .digital_tube1(digital_tube1), .digital_tube_sel1(digital_tube_sel1),
        .digital_tube2(digital_tube2), .digital_tube_sel2(digital_tube_sel2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state: registers plus the number of edges since the last reset edge.
    logic [31:0] m_data, m_ctrl;
    int          k;
    int          shown_idx;
    logic [7:0]  e_t0, e_t1, e_t2;
    logic [3:0]  e_s0, e_s1;
    logic        e_s2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input int edges);
        return (edges / DIV) % 4;
    endfunction

    function automatic logic [7:0] digit_seg(input logic [15:0] grp, input int ix, input logic lzb);
        logic [15:0] hi;
        hi = grp >> (4 * ix);
        if (lzb && ix > 0 && hi == 16'h0)
            return 8'hFF;
        return seg_tab[hi[3:0]];
    endfunction

    task automatic predict(input logic [31:0] d, input logic [31:0] c, input int ix);
        logic [7:0] t2;
        if (!c[0]) begin
            e_s0 = 4'b0000; e_s1 = 4'b0000; e_s2 = 1'b0;
            e_t0 = 8'hFF;   e_t1 = 8'hFF;   e_t2 = 8'hFF;
        end else begin
            e_s0 = 4'(1 << ix);
            e_s1 = e_s0;
            e_s2 = 1'b1;
            e_t0 = digit_seg(d[15:0], ix, c[1]);
            e_t1 = digit_seg(d[31:16], ix, c[1]);
            t2   = seg_tab[c[7:4]];
            e_t2 = {~c[8], t2[6:0]};
        end
    endtask

    task automatic tick();
        logic        r, w;
        logic [1:0]  a;
        logic [31:0] d, exp_rd;
        r = reset; w = we; a = addr; d = wdata;
        @(posedge clk);
        #1;
        if (r) begin
            m_data = 32'h0; m_ctrl = 32'h0; k = 0; shown_idx = 0;
            predict(32'h0, 32'h0, 0);
        end else begin
            shown_idx = m_idx(k);
            predict(m_data, m_ctrl, shown_idx);
            if (w && a == 2'd0) m_data = d;
            if (w && a == 2'd1) m_ctrl = d & 32'h0000_01F3;
            k++;
        end
        check_eq("sel0", {28'h0, digital_tube_sel0}, {28'h0, e_s0});
        check_eq("sel1", {28'h0, digital_tube_sel1}, {28'h0, e_s1});
        check_eq("sel2", {31'h0, digital_tube_sel2}, {31'h0, e_s2});
        check_eq("tube0", {24'h0, digital_tube0}, {24'h0, e_t0});
        check_eq("tube1", {24'h0, digital_tube1}, {24'h0, e_t1});
        check_eq("tube2", {24'h0, digital_tube2}, {24'h0, e_t2});
        case (addr)
            2'd0:    exp_rd = m_data;
            2'd1:    exp_rd = m_ctrl;
            2'd2:    exp_rd = 32'(m_idx(k));
            default: exp_rd = 32'h0;
        endcase
        check_eq("rdata", rdata, exp_rd);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    logic [7:0] scan_t0 [4] = '{8'h80, 8'hF8, 8'h82, 8'h92};
    logic [7:0] scan_t1 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] lzb_t0  [4] = '{8'h92, 8'hC0, 8'h88, 8'hFF};
    logic [7:0] lzb_t1  [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'h0;
        tick();
        tick();
        for (int a = 0; a < 3; a++) begin
            addr = 2'(a);
            #1 check_eq("reset_rdata", rdata, 32'h0);
        end
        reset = 1'b0;

        // Scan order with DATA=0x12345678.
        write_reg(2'd0, 32'h1234_5678);
        write_reg(2'd1, 32'h0000_0001);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("scan_t0", {24'h0, digital_tube0}, {24'h0, scan_t0[shown_idx]});
            check_eq("scan_t1", {24'h0, digital_tube1}, {24'h0, scan_t1[shown_idx]});
        end

        // Leading-zero blanking.
        write_reg(2'd0, 32'h0000_0A05);
        write_reg(2'd1, 32'h0000_0003);
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("lzb_t0", {24'h0, digital_tube0}, {24'h0, lzb_t0[shown_idx]});
            check_eq("lzb_t1", {24'h0, digital_tube1}, {24'h0, lzb_t1[shown_idx]});
        end

        // Single-digit tube with and without dp.
        write_reg(2'd1, 32'h0000_01F1);
        tick();
        check_eq("t2_dp_on", {24'h0, digital_tube2}, 32'h0E);
        write_reg(2'd1, 32'h0000_00F1);
        tick();
        check_eq("t2_dp_off", {24'h0, digital_tube2}, 32'h8E);

        // Disable latency: still active right after the write edge, blank one edge later.
        write_reg(2'd1, 32'h0);
        check_eq("dis_still_on", {31'h0, digital_tube_sel2}, 32'h1);
        tick();
        check_eq("dis_off", {28'h0, digital_tube_sel0}, 32'h0);

        // Reset mid-scan at idx 2.
        write_reg(2'd1, 32'h1);
        for (int i = 0; i < 4 * DIV && m_idx(k) != 2; i++) tick();
        check_eq("pre_rst_idx", 32'(m_idx(k)), 32'h2);
        reset = 1'b1; addr = 2'd2;
        tick();
        reset = 1'b0;
        check_eq("rst_status", rdata, 32'h0);
        for (int i = 0; i < 3 * DIV; i++) tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            we    = ($urandom_range(0, 3) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = {16'($urandom) >> $urandom_range(0, 16), 16'($urandom) >> $urandom_range(0, 16)};
            if (addr == 2'd1 && $urandom_range(0, 3) != 0)
                wdata[0] = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
